mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported, fixed-latency unified memory between the CPU's instruction-fetch side and data side. Serves block reads (cache-line fills) and single-word write-throughs. One transaction is in flight at a time, and simultaneous requests are served round-robin. Sits between the two cache controllers and the memory model inside `cpu`.

## Interface
- `MEM_LAT`, 4, memory read latency in cycles from issue to `mem_rdata` valid (≥1)
- `BLOCK_WORDS`, 8, 16-bit words per block read (power of 2, ≥2)
- `clk` in 1 system clock
- `rst_n` in 1 asynchronous, active-low reset
- `i_req` in 1 instruction-side block-read request, level
- `i_addr` in 16 instruction-side byte address (any byte in block)
- `i_grant` out 1 high for the whole instruction transaction
- `i_data_valid` out 1 pulse: `mem_rdata`/`fill_idx` belong to instruction side
- `i_done` out 1 pulse with last `i_data_valid`
- `d_req` in 1 data-side request, level
- `d_we` in 1 with `d_req`: 1 = single-word write, 0 = block read
- `d_addr` in 16 data-side byte address
- `d_wdata` in 16 write data
- `d_grant`, `d_data_valid`, `d_done` out 1 data-side equivalents of the instruction-side outputs
- `fill_idx` out log2(BLOCK_WORDS) word index of current returned word
- `rdata` out 16 combinational copy of `mem_rdata`
- `mem_en` out 1 memory access strobe
- `mem_wr` out 1 write strobe (only with `mem_en`)
- `mem_addr` out 16 memory byte address
- `mem_wdata` out 16 memory write data
- `mem_rdata` in 16 read data, valid exactly MEM_LAT cycles after a read issue

## Operation
- States: IDLE, RD_ISSUE, RD_DRAIN, WR.
- IDLE:
  - If no request, stay.
  - If exactly one request, grant it.
  - If both requests, grant the side not granted last. `last_grant` resets to I, so D wins the first tie.
- Grant to D with `d_we`=1 goes to WR. Any other grant goes to RD_ISSUE. The owner and the latched base address are registered at grant.
- Base address is the request address with low log2(BLOCK_WORDS)+1 bits zeroed.
- RD_ISSUE:
  - Issue one read per cycle with `mem_en`=1, `mem_wr`=0, `mem_addr` = base + 2·`issue_cnt`.
  - After BLOCK_WORDS issues, go to RD_DRAIN.
- Valid pipeline: a MEM_LAT-deep shift register marks returning words. Each returned word pulses the owner's `*_data_valid` with `fill_idx` = `ret_cnt`, then `ret_cnt` increments.
- The owner's `*_done` pulses with the final return. The next cycle the FSM is in IDLE and `last_grant` is updated.
- WR: a single cycle with `mem_en`=1, `mem_wr`=1, the latched address/data and `d_done`=1, then IDLE.
- Requesters hold `req` until `done`. A `req` drop mid-transaction is ignored and the transaction completes. `req` still high in the IDLE cycle after `done` is treated as a new request.
- `*_grant` is high from the grant cycle through the `done` cycle inclusive. Both grants are never high together.

## Timing
- Reset (async, any state): state = IDLE, counters = 0, valid pipeline cleared, `last_grant` = I. All outputs are 0 except `rdata`, which passes through. In-flight data is discarded.
- Block read, MEM_LAT=4, BLOCK_WORDS=8, `req` seen in IDLE at cycle 0:
  - Grant and first issue in cycle 1.
  - Issues in cycles 1–8.
  - `data_valid` in cycles 5–12, with `done` in cycle 12.
  - IDLE in cycle 13; next grant in cycle 14 at the earliest.
- Generally, the last return is at cycle BLOCK_WORDS+MEM_LAT. Minimum gap between transactions is one IDLE cycle.
- Write: grant, `mem_en`/`mem_wr` and `d_done` all in cycle 1; IDLE in cycle 2.
- `fill_idx` counts 0 to BLOCK_WORDS−1 and is valid only with `*_data_valid`. Counters wrap to 0 at transaction end.
- No combinational path from any `req` to any `mem_*` output. All outputs except `rdata` are registered or decoded from registered state.

## Structure
- Package `arb_pkg`:
  - `arb_state_t` enum (IDLE, RD_ISSUE, RD_DRAIN, WR)
  - `owner_t` enum (OWN_I, OWN_D)
  - `WORD_BYTES` = 2
- Sub-module `mem_valid_pipe`: parameterized MEM_LAT-deep 1-bit shift register with async clear. Input is the issue strobe; output is the return strobe.

## Test plan
- Single I read, `i_addr`=0x1236 → `mem_addr` 0x1230..0x123E over cycles 1–8; `i_data_valid` cycles 5–12 with `fill_idx` 0..7; `i_done` at cycle 12.
- D write, `d_addr`=0x00A0, `d_wdata`=0xBEEF → one cycle of `mem_en`=`mem_wr`=1, `mem_addr`=0x00A0, `mem_wdata`=0xBEEF; `d_done` in the same cycle.
- `i_req` and `d_req`(read) asserted together from reset and held → D served first, then I, then D. Grants never overlap, with exactly one IDLE cycle between transactions.
- `i_req` dropped at cycle 3 of a fill → all 8 words still return and `i_done` still fires.
- `rst_n` low during cycle 6 of a fill → all outputs 0 immediately, no `data_valid` after reset. A fresh request after release starts at `fill_idx` 0.
- `d_req` write arriving mid I-fill → `d_grant` stays low until the I-fill completes. The write is issued in the first grant cycle after IDLE.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Both cache controllers address memory in bytes; every word is 16 bits wide.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    WR       = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned WORD_BYTES = 32'd2;

  // Clear the byte offset within a block so fills always start on a block boundary.
  function automatic logic [15:0] block_base(input logic [15:0] addr,
                                             input int unsigned block_words);
    return addr & ~(16'(block_words * WORD_BYTES) - 16'd1);
  endfunction

endpackage

// File: rtl/mem_valid_pipe.sv
// Marks which cycles carry returning read data.
// A read issued in cycle N comes back as a strobe in cycle N+MEM_LAT.
module mem_valid_pipe #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic ret
);

  logic [MEM_LAT-1:0] sr_r;

  // Shift the issue strobe down the pipe; reset drops any in-flight returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= '0;
    end else begin
      sr_r[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        sr_r[i] <= sr_r[i-1];
      end
    end
  end

  assign ret = sr_r[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-ported, fixed-latency memory between
// the instruction-fetch and data caches. One transaction is in flight at a time.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req,
  input  logic [15:0]                    i_addr,
  output logic                           i_grant,
  output logic                           i_data_valid,
  output logic                           i_done,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [15:0]                    d_addr,
  input  logic [15:0]                    d_wdata,
  output logic                           d_grant,
  output logic                           d_data_valid,
  output logic                           d_done,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
  output logic [15:0]                    rdata,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  owner_t           owner_r;
  owner_t           last_grant_r;
  logic [15:0]      addr_r;
  logic [15:0]      wdata_r;
  logic [IDX_W-1:0] issue_cnt_r;
  logic [IDX_W-1:0] ret_cnt_r;

  logic             req_any_s;
  logic             pick_d_s;
  logic             issue_s;
  logic             ret_s;
  logic             last_ret_s;
  logic             own_i_s;
  logic             active_s;
  logic [15:0]      offset_s;

  assign req_any_s  = i_req | d_req;
  // On a tie, serve the side that was not granted last.
  assign pick_d_s   = d_req & (~i_req | (last_grant_r == OWN_I));
  assign issue_s    = (state_r == RD_ISSUE);
  assign last_ret_s = ret_s & (ret_cnt_r == LAST_IDX);
  assign own_i_s    = (owner_r == OWN_I);
  assign active_s   = (state_r != IDLE);
  assign offset_s   = 16'(issue_cnt_r) * 16'(WORD_BYTES);

  mem_valid_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .issue(issue_s),
    .ret  (ret_s)
  );

  // Next-state decode for the transaction FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_any_s) begin
          if (pick_d_s && d_we) begin
            state_nxt_s = WR;
          end else begin
            state_nxt_s = RD_ISSUE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_ISSUE: begin
        if (issue_cnt_r == LAST_IDX) begin
          state_nxt_s = RD_DRAIN;
        end else begin
          state_nxt_s = RD_ISSUE;
        end
      end
      RD_DRAIN: begin
        if (last_ret_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_DRAIN;
        end
      end
      WR:      state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, grant bookkeeping and latched transaction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      owner_r      <= OWN_I;
      last_grant_r <= OWN_I;
      addr_r       <= 16'h0000;
      wdata_r      <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && req_any_s) begin
        owner_r <= pick_d_s ? OWN_D : OWN_I;
        wdata_r <= d_wdata;
        if (pick_d_s) begin
          addr_r <= d_we ? d_addr : block_base(d_addr, BLOCK_WORDS);
        end else begin
          addr_r <= block_base(i_addr, BLOCK_WORDS);
        end
      end
      if ((state_r == RD_DRAIN && last_ret_s) || state_r == WR) begin
        last_grant_r <= owner_r;
      end
    end
  end

  // Issue and return counters; both wrap to zero at the end of a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r <= '0;
      ret_cnt_r   <= '0;
    end else begin
      if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + IDX_W'(1);
      end
      if (ret_s) begin
        ret_cnt_r <= ret_cnt_r + IDX_W'(1);
      end
    end
  end

  assign i_grant      = active_s & own_i_s;
  assign d_grant      = active_s & ~own_i_s;
  assign i_data_valid = ret_s & own_i_s;
  assign d_data_valid = ret_s & ~own_i_s;
  assign i_done       = last_ret_s & own_i_s;
  assign d_done       = (last_ret_s & ~own_i_s) | (state_r == WR);
  assign fill_idx     = ret_s ? ret_cnt_r : '0;
  assign rdata        = mem_rdata;
  assign mem_en       = issue_s | (state_r == WR);
  assign mem_wr       = (state_r == WR);
  assign mem_addr     = issue_s ? (addr_r + offset_s) :
                        ((state_r == WR) ? addr_r : 16'h0000);
  assign mem_wdata    = (state_r == WR) ? wdata_r : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a fixed-latency memory model that
// returns (issued address ^ 0x5A00) exactly LAT cycles after each read issue.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        i_grant, i_data_valid, i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  logic        d_grant, d_data_valid, d_done;
  logic [2:0]  fill_idx;
  logic [15:0] rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad = 0;

  logic [15:0] mq [0:LAT-1];

  mem_arbiter #(.MEM_LAT(LAT), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
    .i_data_valid(i_data_valid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data_valid(d_data_valid), .d_done(d_done),
    .fill_idx(fill_idx), .rdata(rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) mq[i] <= 16'h0000;
    end else begin
      mq[0] <= (mem_en && !mem_wr) ? mem_addr : 16'h0000;
      for (int i = 1; i < LAT; i++) mq[i] <= mq[i-1];
    end
  end
  assign mem_rdata = mq[LAT-1] ^ 16'h5A00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done, fill_idx,
         mem_en, mem_wr, mem_addr, mem_wdata} !== 41'd0) begin
      bad++;
      $display("FAIL reset_outputs got mem_en=%b mem_addr=%h grants=%b%b", mem_en, mem_addr, i_grant, d_grant);
    end
    total++;
    if (rdata !== 16'h5A00) begin
      bad++;
      $display("FAIL reset_rdata_passthru got=%h exp=5a00", rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    logic        e_en, e_v;
    logic [15:0] e_addr;
    step();
    i_req = 1'b1;
    i_addr = 16'h1236;
    for (int c = 1; c <= 14; c++) begin
      step();
      e_en = (c <= 8);
      e_v = (c >= 5 && c <= 12);
      e_addr = e_en ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0000;
      total++;
      if ({i_grant, i_data_valid, i_done, mem_en, mem_wr, d_grant} !==
          {(c <= 12), e_v, (c == 12), e_en, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL rd_ctrl c=%0d got=%b exp=%b", c,
                 {i_grant, i_data_valid, i_done, mem_en, mem_wr, d_grant},
                 {(c <= 12), e_v, (c == 12), e_en, 1'b0, 1'b0});
      end
      total++;
      if (mem_addr !== e_addr) begin
        bad++;
        $display("FAIL rd_addr c=%0d got=%h exp=%h", c, mem_addr, e_addr);
      end
      if (e_v) begin
        total++;
        if (fill_idx !== 3'(c - 5) || rdata !== ((16'h1230 + 16'(2 * (c - 5))) ^ 16'h5A00)) begin
          bad++;
          $display("FAIL rd_data c=%0d got idx=%0d data=%h exp idx=%0d", c, fill_idx, rdata, c - 5);
        end
      end
      if (c == 12) i_req = 1'b0;
    end
  endtask

  task automatic test_write();
    step();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 16'h00A0;
    d_wdata = 16'hBEEF;
    step();
    total++;
    if ({d_grant, mem_en, mem_wr, d_done, i_grant, d_data_valid} !== 6'b111100 ||
        mem_addr !== 16'h00A0 || mem_wdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_cycle got ctrl=%b addr=%h data=%h exp ctrl=111100 addr=00a0 data=beef",
               {d_grant, mem_en, mem_wr, d_done, i_grant, d_data_valid}, mem_addr, mem_wdata);
    end
    d_req = 1'b0;
    d_we = 1'b0;
    step();
    total++;
    if ({d_grant, mem_en, mem_wr, d_done} !== 4'b0000) begin
      bad++;
      $display("FAIL wr_after got=%b exp=0000", {d_grant, mem_en, mem_wr, d_done});
    end
  endtask

  task automatic test_round_robin();
    logic e_d, e_i;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    i_req = 1'b1;
    i_addr = 16'h1000;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 16'h2222;
    for (int c = 1; c <= 39; c++) begin
      step();
      e_d = (c >= 1 && c <= 12) || (c >= 27 && c <= 38);
      e_i = (c >= 14 && c <= 25);
      total++;
      if (i_grant !== e_i || d_grant !== e_d) begin
        bad++;
        $display("FAIL rr_grant c=%0d got i=%b d=%b exp i=%b d=%b", c, i_grant, d_grant, e_i, e_d);
      end
      if (c == 13 || c == 26) begin
        total++;
        if (mem_en !== 1'b0) begin
          bad++;
          $display("FAIL rr_idle_gap c=%0d mem_en got=%b exp=0", c, mem_en);
        end
      end
      if (c == 1 || c == 14 || c == 27) begin
        total++;
        if (mem_addr !== ((c == 14) ? 16'h1000 : 16'h2220)) begin
          bad++;
          $display("FAIL rr_addr c=%0d got=%h", c, mem_addr);
        end
      end
      if (c == 5 || c == 18) begin
        total++;
        if (d_data_valid !== (c == 5) || i_data_valid !== (c == 18)) begin
          bad++;
          $display("FAIL rr_valid_owner c=%0d got i=%b d=%b", c, i_data_valid, d_data_valid);
        end
      end
      if (c == 38) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_drop();
    int nvalid = 0;
    step();
    i_req = 1'b1;
    i_addr = 16'h3012;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 3) i_req = 1'b0;
      if (i_data_valid === 1'b1) begin
        total++;
        if (fill_idx !== 3'(nvalid) || rdata !== ((16'h3010 + 16'(2 * nvalid)) ^ 16'h5A00)) begin
          bad++;
          $display("FAIL drop_data n=%0d got idx=%0d data=%h", nvalid, fill_idx, rdata);
        end
        nvalid++;
      end
      total++;
      if (i_done !== (c == 12)) begin
        bad++;
        $display("FAIL drop_done c=%0d got=%b exp=%b", c, i_done, (c == 12));
      end
    end
    total++;
    if (nvalid !== 8) begin
      bad++;
      $display("FAIL drop_count got=%0d exp=8", nvalid);
    end
  endtask

  task automatic test_write_mid_fill();
    step();
    i_req = 1'b1;
    i_addr = 16'h2000;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 3) begin
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 16'h0100;
        d_wdata = 16'h1234;
      end
      if (c <= 13) begin
        total++;
        if (d_grant !== 1'b0 || mem_wr !== 1'b0 || i_done !== (c == 12)) begin
          bad++;
          $display("FAIL wmf_hold c=%0d got dg=%b wr=%b idone=%b", c, d_grant, mem_wr, i_done);
        end
      end else begin
        total++;
        if ({d_grant, mem_en, mem_wr, d_done, i_grant} !== 5'b11110 ||
            mem_addr !== 16'h0100 || mem_wdata !== 16'h1234) begin
          bad++;
          $display("FAIL wmf_write got ctrl=%b addr=%h data=%h exp 11110 0100 1234",
                   {d_grant, mem_en, mem_wr, d_done, i_grant}, mem_addr, mem_wdata);
        end
        d_req = 1'b0;
        d_we = 1'b0;
      end
      if (c == 12) i_req = 1'b0;
    end
    step();
  endtask

  task automatic test_reset_mid();
    step();
    i_req = 1'b1;
    i_addr = 16'h4008;
    for (int c = 1; c <= 6; c++) step();
    rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    total++;
    if ({i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done, fill_idx,
         mem_en, mem_wr, mem_addr, mem_wdata} !== 41'd0) begin
      bad++;
      $display("FAIL rstmid_outputs got grant=%b valid=%b mem_en=%b addr=%h", i_grant, i_data_valid, mem_en, mem_addr);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if (i_data_valid !== 1'b0 || mem_en !== 1'b0 || i_grant !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_quiet c=%0d got valid=%b en=%b grant=%b exp 0", c, i_data_valid, mem_en, i_grant);
      end
    end
    i_req = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) begin
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h4000) begin
          bad++;
          $display("FAIL rstmid_fresh_issue got en=%b addr=%h exp 1 4000", mem_en, mem_addr);
        end
      end
      if (c == 5 || c == 12) begin
        total++;
        if (i_data_valid !== 1'b1 || fill_idx !== ((c == 5) ? 3'd0 : 3'd7) || i_done !== (c == 12)) begin
          bad++;
          $display("FAIL rstmid_fresh_ret c=%0d got v=%b idx=%0d done=%b", c, i_data_valid, fill_idx, i_done);
        end
      end
      if (c == 12) i_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_drop();
    test_write_mid_fill();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
